// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan/manual bit serializer.
package scan_mux_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_serializer_bit_select_mux.sv
// Combinational WIDTH:1 bit selector. Out-of-range indices select 0 and
// clear in_range, so WIDTH need not be a power of two.
module bit_select_mux #(
  parameter int WIDTH = 32,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] idx,
  output logic             bit_o,
  output logic             in_range
);

  // One extra bit so WIDTH itself is representable in the comparison.
  localparam logic [SEL_W:0] WIDTH_EXT = (SEL_W + 1)'(WIDTH);

  always_comb begin
    in_range = ({1'b0, idx} < WIDTH_EXT);
    bit_o    = 1'b0;
    if (in_range) begin
      bit_o = data[idx];
    end
  end

endmodule

// File: rtl/scan_mux_serializer.sv
// Manual WIDTH:1 bit select, or valid/ready word capture followed by
// bit-serial emission (LSB- or MSB-first) with bubble-free streaming.
module scan_mux_serializer #(
  parameter int WIDTH = 32,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic             msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);
  import scan_mux_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  // Handshake: a word on `in` transfers at a rising edge exactly when
  // in_valid && in_ready; in_ready is combinational from state/idx/mode.

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               order_q, order_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic               sh_bit, sh_in_range;
  logic               man_bit, man_in_range;
  logic               idx_is_final;

  bit_select_mux #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_shift_mux (
    .data     (shadow_q),
    .idx      (idx_q),
    .bit_o    (sh_bit),
    .in_range (sh_in_range)
  );

  bit_select_mux #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_manual_mux (
    .data     (in),
    .idx      (sel),
    .bit_o    (man_bit),
    .in_range (man_in_range)
  );

  assign idx_is_final = (idx_q == (order_q ? '0 : LAST_IDX));

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    order_d     = order_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_MANUAL) begin
          out_d       = man_bit;
          out_valid_d = man_in_range;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            shadow_d = in;
            order_d  = msb_first;
            idx_d    = msb_first ? LAST_IDX : '0;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        out_d       = sh_bit;
        out_valid_d = sh_in_range;
        out_last_d  = idx_is_final;
        if (idx_is_final) begin
          // Final bit goes out this edge; a waiting word loads with no gap.
          in_ready = 1'b1;
          if (in_valid) begin
            shadow_d = in;
            order_d  = msb_first;
            idx_d    = msb_first ? LAST_IDX : '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = order_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      order_q     <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      order_q     <= order_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_scan_mux_serializer.sv
// Directed bench for scan_mux_serializer at WIDTH=32 and WIDTH=5.
module tb_scan_mux_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] in_w;
  logic [4:0]  sel;
  logic        mode, msb_first, in_valid;
  logic        in_ready, out_b, out_valid, out_last, busy;

  logic [4:0]  in_5;
  logic [2:0]  sel_5;
  logic        mode_5, msb_first_5, in_valid_5;
  logic        in_ready_5, out_5, out_valid_5, out_last_5, busy_5;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] word;
  logic [4:0]  word_5;

  always #5 clk = ~clk;

  scan_mux_serializer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_w),
    .sel       (sel),
    .mode      (mode),
    .msb_first (msb_first),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_b),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
  );

  scan_mux_serializer #(.WIDTH(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in        (in_5),
    .sel       (sel_5),
    .mode      (mode_5),
    .msb_first (msb_first_5),
    .in_valid  (in_valid_5),
    .in_ready  (in_ready_5),
    .out       (out_5),
    .out_valid (out_valid_5),
    .out_last  (out_last_5),
    .busy      (busy_5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_w = '0; sel = '0; mode = 1'b0; msb_first = 1'b0; in_valid = 1'b0;
    in_5 = '0; sel_5 = '0; mode_5 = 1'b0; msb_first_5 = 1'b0; in_valid_5 = 1'b0;
    tick(); tick();
    check("rst_out", out_b, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready_manual", in_ready, 1'b0);

    // Manual select
    rst = 1'b0; in_w = 32'hA5A5_0F0F; sel = 5'd8;
    tick();
    check("man_sel8_out", out_b, 1'b1);
    check("man_sel8_valid", out_valid, 1'b1);
    check("man_sel8_last", out_last, 1'b0);
    check("man_ready", in_ready, 1'b0);
    sel = 5'd4;
    tick();
    check("man_sel4_out", out_b, 1'b0);
    check("man_sel4_valid", out_valid, 1'b1);
    sel = 5'd16;
    tick();
    check("man_sel16_out", out_b, 1'b1);

    // LSB-first scan of 32'h1
    mode = 1'b1; in_w = 32'h0000_0001; msb_first = 1'b0; in_valid = 1'b1;
    #1;
    check("scan_idle_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_w = 32'hFFFF_FFFF;
    check("lsb_accept_busy", busy, 1'b1);
    check("lsb_accept_valid", out_valid, 1'b0);
    check("lsb_accept_ready", in_ready, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("lsb_out", out_b, (i == 0));
      check("lsb_valid", out_valid, 1'b1);
      check("lsb_last", out_last, (i == 31));
      check("lsb_ready", in_ready, (i >= 30));
    end
    check("lsb_end_busy", busy, 1'b0);
    tick();
    check("lsb_idle_valid", out_valid, 1'b0);
    check("lsb_idle_last", out_last, 1'b0);
    check("lsb_idle_hold", out_b, 1'b0);

    // MSB-first scan; mode/msb_first changes mid-word must be ignored
    word = 32'h8000_0003; in_w = word; msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; msb_first = 1'b0; mode = 1'b0; in_w = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("msb_out", out_b, word[31 - i]);
      check("msb_valid", out_valid, 1'b1);
      check("msb_last", out_last, (i == 31));
    end
    check("msb_end_busy", busy, 1'b0);

    // Back-to-back A then B with in_valid held high
    mode = 1'b1; msb_first = 1'b0; in_w = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_w = 32'h0000_0000;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 31) in_valid = 1'b0;
      check("b2b_out", out_b, (i < 32));
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_last", out_last, (i == 31 || i == 63));
      check("b2b_busy", busy, (i < 63));
    end
    tick();
    check("b2b_idle_valid", out_valid, 1'b0);

    // Reset while bit 10 is due
    in_w = 32'h0000_FFFF; msb_first = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_out", out_b, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out", out_b, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_last", out_last, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    check("postrst_valid", out_valid, 1'b0);
    check("postrst_busy", busy, 1'b0);
    in_w = 32'h0000_0002; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("postrst_accept_busy", busy, 1'b1);
    tick();
    check("postrst_bit0", out_b, 1'b0);
    check("postrst_bit0_valid", out_valid, 1'b1);
    tick();
    check("postrst_bit1", out_b, 1'b1);
    for (int i = 2; i < 32; i++) tick();
    check("postrst_last", out_last, 1'b1);
    check("postrst_out31", out_b, 1'b0);

    // WIDTH=5 instance
    word_5 = 5'b10110; in_5 = word_5; mode_5 = 1'b0; sel_5 = 3'd1;
    tick();
    check("w5_sel1_out", out_5, 1'b1);
    check("w5_sel1_valid", out_valid_5, 1'b1);
    sel_5 = 3'd6;
    tick();
    check("w5_sel6_out", out_5, 1'b0);
    check("w5_sel6_valid", out_valid_5, 1'b0);
    sel_5 = 3'd4;
    tick();
    check("w5_sel4_out", out_5, 1'b1);
    check("w5_sel4_valid", out_valid_5, 1'b1);
    sel_5 = 3'd5;
    tick();
    check("w5_sel5_valid", out_valid_5, 1'b0);

    mode_5 = 1'b1; msb_first_5 = 1'b0; in_valid_5 = 1'b1;
    tick();
    in_valid_5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w5_lsb_out", out_5, word_5[i]);
      check("w5_lsb_valid", out_valid_5, 1'b1);
      check("w5_lsb_last", out_last_5, (i == 4));
    end
    check("w5_lsb_end_busy", busy_5, 1'b0);

    msb_first_5 = 1'b1; in_valid_5 = 1'b1;
    tick();
    in_valid_5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w5_msb_out", out_5, word_5[4 - i]);
      check("w5_msb_last", out_last_5, (i == 4));
    end
    tick();
    check("w5_msb_idle_valid", out_valid_5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
